// File: rtl/interleaver_pkg.sv
// Shared types and helpers for the ping-pong block interleaver controller.
package interleaver_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StStream,
    StDrain
  } state_e;

  localparam logic MODE_INTLV   = 1'b0;
  localparam logic MODE_DEINTLV = 1'b1;

  function automatic int unsigned addr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interleaver_ctrl_if.sv
// Stream handshake and datapath addressing bundle between controller and datapath/stream ends.
interface interleaver_ctrl_if #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4
);
  import interleaver_pkg::*;

  localparam int unsigned AW = addr_width(ROWS * COLS);

  logic          mode;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic          frame_start;
  logic          busy;

  modport master (
    input  mode, flush, in_valid, out_ready,
    output in_ready, out_valid, wr_en, wr_bank, wr_addr, rd_bank, rd_addr, frame_start, busy
  );

  modport slave (
    output mode, flush, in_valid, out_ready,
    input  in_ready, out_valid, wr_en, wr_bank, wr_addr, rd_bank, rd_addr, frame_start, busy
  );

endinterface

// File: rtl/interleaver_addr_gen.sv
// Combinational read permutation: maps read count k to the row-major bank index.
module interleaver_addr_gen
  import interleaver_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4,
  parameter int unsigned AW   = addr_width(ROWS * COLS)
) (
  input  logic [AW-1:0] k,
  input  logic          mode,
  output logic [AW-1:0] addr
);

  logic [31:0] kk;

  assign kk = 32'(k);

  always_comb begin
    if (mode == MODE_DEINTLV) begin
      addr = AW'((kk % COLS) * ROWS + kk / COLS);
    end else begin
      addr = AW'((kk % ROWS) * COLS + kk / ROWS);
    end
  end

endmodule

// File: rtl/interleaver_ctrl.sv
// Ping-pong interleaver sequencer: fills one bank while the other is read out permuted,
// with lossless back-pressure and an explicit drain of the last frame on flush.
module interleaver_ctrl
  import interleaver_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 4
) (
  input logic              clk,
  input logic              rst,
  interleaver_ctrl_if.master bus
);

  localparam int unsigned N    = ROWS * COLS;
  localparam int unsigned AW   = addr_width(N);
  localparam logic [AW-1:0] Last = AW'(N - 1);

  state_e        state_q;
  logic          wr_bank_q;
  logic [AW-1:0] wr_cnt_q;
  logic [AW-1:0] rd_cnt_q;
  logic [1:0]    bank_mode_q;

  logic          in_ready;
  logic          out_valid;
  logic          in_beat;
  logic          out_beat;
  logic          wr_last;
  logic          rd_last;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;

  // in_ready is gated by the reset pin so it reads 0 while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle, StFill: in_ready = 1'b1;
      StStream: begin
        in_ready  = bus.out_ready;
        out_valid = bus.in_valid;
      end
      StDrain: out_valid = 1'b1;
      default: ;
    endcase
    in_ready = in_ready & rst;
  end

  assign in_beat  = bus.in_valid & in_ready;
  assign out_beat = out_valid & bus.out_ready;
  assign wr_last  = (wr_cnt_q == Last);
  assign rd_last  = (rd_cnt_q == Last);
  assign rd_bank  = ~wr_bank_q;

  // Read order follows the mode captured when the bank being read was started.
  interleaver_addr_gen #(
    .ROWS (ROWS),
    .COLS (COLS),
    .AW   (AW)
  ) u_addr_gen (
    .k    (rd_cnt_q),
    .mode (bank_mode_q[rd_bank]),
    .addr (rd_addr)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      bank_mode_q <= '0;
    end else begin
      if (in_beat) begin
        if (wr_cnt_q == '0) begin
          bank_mode_q[wr_bank_q] <= bus.mode;
        end
        wr_cnt_q <= wr_last ? '0 : wr_cnt_q + AW'(1);
      end
      if (out_beat) begin
        rd_cnt_q <= rd_last ? '0 : rd_cnt_q + AW'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (in_beat) state_q <= StFill;
        end
        StFill: begin
          if (in_beat && wr_last) begin
            wr_bank_q <= ~wr_bank_q;
            state_q   <= StStream;
          end
        end
        StStream: begin
          if (in_beat && wr_last) begin
            wr_bank_q <= ~wr_bank_q;
          end else if (!in_beat && bus.flush && (wr_cnt_q == '0)) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (out_beat && rd_last) begin
            wr_bank_q <= ~wr_bank_q;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.wr_en       = in_beat;
  assign bus.wr_bank     = wr_bank_q;
  assign bus.wr_addr     = wr_cnt_q;
  assign bus.rd_bank     = rd_bank;
  assign bus.rd_addr     = rd_addr;
  assign bus.frame_start = in_beat & (wr_cnt_q == '0);
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: doc/interleaver_ctrl.md
# interleaver_ctrl

Sequencing controller for the ping-pong block interleaver datapath. It owns the two ROWS×COLS bit banks' write/read addressing, bank swapping and the stream-level valid/ready handshakes. The datapath only stores bits and muxes the read bit out. The controller sits between the upstream bit source (e.g. encoder) and the downstream modulator. It guarantees lossless, back-pressurable streaming with one frame of latency and an explicit drain at end of stream.

## Interface
- ROWS, 4, interleaver rows; ≥2
- COLS, 4, interleaver columns; ≥2
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- mode  in  1  0 = interleave, 1 = deinterleave; sampled per frame
- flush  in  1  level; end-of-stream request, honoured only at frame boundary
- in_valid  in  1  upstream bit present
- in_ready  out  1  controller accepts upstream bit
- out_valid  out  1  datapath read bit is valid this cycle
- out_ready  in  1  downstream accepts bit
- wr_en  out  1  datapath writes data_i into bank[wr_bank][wr_addr]
- wr_bank  out  1  bank being filled
- wr_addr  out  AW  write index, AW = $clog2(ROWS*COLS)
- rd_bank  out  1  bank being read, always !wr_bank when reading
- rd_addr  out  AW  permuted read index (datapath read is combinational)
- frame_start  out  1  one-cycle pulse on the beat writing index 0
- busy  out  1  state ≠ IDLE

## Operation
- N = ROWS*COLS. wr_cnt and rd_cnt are 0..N-1 and wrap to 0 after N-1.
- Write order is row-major: wr_addr = wr_cnt.
- Read permutation for k = rd_cnt:
  - interleave: (k mod ROWS)*COLS + k div ROWS
  - deinterleave: (k mod COLS)*ROWS + k div COLS
- The mode used for a read is the mode latched into bank_mode[wr_bank] on that bank's wr_cnt=0 beat, not the live input.
- States:
  - IDLE: in_ready=1, out_valid=0. An in beat writes index 0 and moves to FILL.
  - FILL: in_ready=1, out_valid=0. The beat writing N-1 toggles wr_bank and moves to STREAM.
  - STREAM: in_ready=out_ready, out_valid=in_valid. A beat is in_valid&&out_ready, which writes and reads simultaneously. A beat at wr_cnt=N-1 toggles wr_bank, and rd_cnt wraps with it.
  - STREAM → DRAIN when flush=1 at wr_cnt=0 in a cycle with no beat.
  - DRAIN: in_ready=0, out_valid=1. Reads the last full bank on out_ready. The beat at rd_cnt=N-1 moves to IDLE and toggles wr_bank.
- Writes: wr_en = in_valid&&in_ready. Reads happen only when out_valid&&out_ready.
- flush mid-frame is held off until the frame completes; no padding is generated.
- flush in IDLE has no effect; a frame partially filled in FILL is never emitted until completed.

## Timing
- Reset values: state=IDLE, wr_bank=0, rd_bank=1, wr_cnt=rd_cnt=0, bank_mode=0, in_ready=0 during reset (1 after release), out_valid=0, wr_en=0, frame_start=0, busy=0.
- wr_addr, rd_addr, rd_bank and out_valid are combinational from registered state. Data for the first output bit is valid in the cycle after the N-th input beat.
- Latency: an input bit written in frame f is emitted during frame f+1; minimum latency is N beats.
- Back-pressure: out_ready=0 in STREAM stalls both sides. No bit is lost or duplicated, and counters hold.
- An in_valid drop in STREAM holds both counters; out_valid=0 that cycle.
- Reset mid-frame discards both banks; the next frame begins in IDLE.

## Structure
- interleaver_pkg:
  - state enum (IDLE, FILL, STREAM, DRAIN)
  - mode constants (MODE_INTLV=0, MODE_DEINTLV=1)
  - addr-width function
- Sub-module interleaver_addr_gen: combinational permutation (k, mode, ROWS, COLS → addr), reused by the datapath bench as a reference model.

## Test plan
- ROWS=COLS=4, mode=0:
  - stimulus: two frames of bits, value = index parity pattern 0..15, flush after frame 2
  - required: rd_addr sequence 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15 twice; then IDLE, busy=0
- mode toggle: frame 1 mode=0, frame 2 mode=1, ROWS=2, COLS=4
  - required: frame 1 reads 0,4,1,5,2,6,3,7
  - required: frame 2 reads 0,2,4,6,1,3,5,7, using per-bank latched mode
- Back-pressure: random out_ready at 50% during STREAM
  - required: emitted bit stream equals the reference-model permutation exactly
  - required: in_ready tracks out_ready cycle-for-cycle
- flush asserted at wr_cnt=7
  - required: 8 more beats accepted
  - required: DRAIN entered only after wr_cnt wraps to 0
  - required: exactly 16 drain beats with in_ready=0
- Async reset asserted mid-STREAM at wr_cnt=9
  - required: all outputs take reset values immediately
  - required: next frame_start accompanies wr_addr=0, out_valid=0 until 16 beats are written
